dat_mem_mover: RTL

- Block-transfer engine that acts as the initiator on the data-memory port: drives address, write data and write enable, and consumes the combinational read data.
- Copies a run of bytes from one data-memory region to another (memmove semantics), or fills a region with a constant.
- Sits beside the processor datapath; an external mux hands it the memory port while busy is high.

---
 rtl/dat_mem_mover_if.sv | 30 +++
 rtl/dat_mem_mover.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dat_mem_mover_if.sv
// Memory-port and command bundle for the block mover.
// master = mover side; slave = command source plus memory side.
interface dat_mem_mover_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic [DW-1:0] fill_val;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] count;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    output mem_addr, mem_wdata, mem_wr_en, busy, done, count
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr_en, busy, done, count
  );
endinterface

// File: rtl/dat_mem_mover.sv
// Block copy (memmove) / fill engine driving the data-memory port.
// Copy costs 2 cycles per byte (read, write), fill 1 cycle per byte; all outputs registered.
module dat_mem_mover #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dat_mem_mover_if.master       bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] len_q, len_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          mode_q, mode_d;
  logic          bwd_q, bwd_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] step;
  logic [AW-1:0] diff;

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    buf_d       = buf_q;
    len_d       = len_q;
    fill_d      = fill_q;
    mode_d      = mode_q;
    bwd_d       = bwd_q;
    count_d     = count_q;
    step        = bwd_q ? {AW{1'b1}} : AW'(1);
    diff        = bus.dst_addr - bus.src_addr;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          len_d   = bus.len;
          fill_d  = bus.fill_val;
          count_d = '0;
          // Walk backward only when the destination starts inside the source run.
          bwd_d   = !bus.mode && (diff != '0) && (diff < bus.len);
          if (bwd_d) begin
            src_ptr_d = bus.src_addr + bus.len - AW'(1);
            dst_ptr_d = bus.dst_addr + bus.len - AW'(1);
          end else begin
            src_ptr_d = bus.src_addr;
            dst_ptr_d = bus.dst_addr;
          end
          if (bus.len == '0)   state_d = DONE;
          else if (bus.mode)   state_d = WR;
          else                 state_d = RD;
        end
      end
      RD: begin
        buf_d     = bus.mem_rdata;
        src_ptr_d = src_ptr_q + step;
        state_d   = WR;
      end
      WR: begin
        count_d   = count_q + AW'(1);
        dst_ptr_d = dst_ptr_q + step;
        if (count_d == len_q) state_d = DONE;
        else if (mode_q)      state_d = WR;
        else                  state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are decoded from the next state so they line up with it.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wr_en_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      RD: begin
        mem_addr_d = src_ptr_d;
        busy_d     = 1'b1;
      end
      WR: begin
        mem_addr_d  = dst_ptr_d;
        mem_wdata_d = mode_d ? fill_d : buf_d;
        mem_wr_en_d = 1'b1;
        busy_d      = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      buf_q       <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      mode_q      <= 1'b0;
      bwd_q       <= 1'b0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      mode_q      <= mode_d;
      bwd_q       <= bwd_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule
